// File: rtl/alu_sub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_sub_seq_ctrl
//   Sequencer and arbiter that shares one combinational 32-bit subtractor
//   between two requesters. A narrow op takes one pass through the unit.
//   A wide op takes two passes: the low word first, then the high word, with
//   the borrow from the low pass fed in as the high pass borrow-in. Results
//   return on one response channel, tagged with the requester ID.
//
//   Optional build macro: ALU_SEQ_STATS_EN. It adds STAT_CNT0/STAT_CNT1,
//   which are saturating per-requester counts of completed responses.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   REQn_VALID/READY      request handshake. READY pulses for one cycle on
//                         grant and is only ever asserted in IDLE.
//   REQn_X/Y [63:0]       minuend / subtrahend (bits [63:32] unused if narrow)
//   REQn_WIDE, REQn_B_IN  64-bit select, borrow-in
//   RSP_VALID/READY       response handshake
//   RSP_ID, RSP_Z[63:0]   owner of the result, difference
//   RSP_B_OUT             final borrow-out
//   SUB_X/Y[31:0],SUB_C_IN   drive the external subtractor (0 when unused)
//   SUB_Z[31:0],SUB_C_OUT    subtractor result, sampled in the same cycle
//   STAT_CNT0/1[STAT_W-1:0]  (ALU_SEQ_STATS_EN only) response counters
// ---------------------------------------------------------------------------
module alu_sub_seq_ctrl #(
  parameter int STAT_W = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [63:0] REQ0_X,
  input  logic [63:0] REQ0_Y,
  input  logic        REQ0_WIDE,
  input  logic        REQ0_B_IN,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [63:0] REQ1_X,
  input  logic [63:0] REQ1_Y,
  input  logic        REQ1_WIDE,
  input  logic        REQ1_B_IN,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [63:0] RSP_Z,
  output logic        RSP_B_OUT,
  output logic [31:0] SUB_X,
  output logic [31:0] SUB_Y,
  output logic        SUB_C_IN,
  input  logic [31:0] SUB_Z,
  input  logic        SUB_C_OUT
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] STAT_CNT0,
  output logic [STAT_W-1:0] STAT_CNT1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_last;          // requester granted most recently
  logic [63:0] r_x, r_y, r_z;
  logic        r_wide, r_bin, r_id, r_borrow;
  logic        w_gnt0, w_gnt1, w_any;

  // STAT_W only sizes the optional counters; a zero width is not meaningful.
  if (STAT_W < 1) begin : g_stat_w_invalid
  end

  // Round-robin between two: a lone requester always wins, and on contention
  // the one that did not win last time goes. r_last resets to 1 so that
  // requester 0 takes the first contended grant.
  always_comb begin
    w_gnt1 = REQ1_VALID && (!REQ0_VALID || !r_last);
    w_gnt0 = REQ0_VALID && !w_gnt1;
    w_any  = w_gnt0 || w_gnt1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    SUB_X      = 32'd0;
    SUB_Y      = 32'd0;
    SUB_C_IN   = 1'b0;
    RSP_VALID  = 1'b0;
    RSP_ID     = 1'b0;
    RSP_Z      = 64'd0;
    RSP_B_OUT  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // READY is masked by reset so every output reads 0 while held in reset.
        REQ0_READY = w_gnt0 && RST_N;
        REQ1_READY = w_gnt1 && RST_N;
        if (w_any) w_next = S_LO;
      end
      S_LO: begin
        SUB_X    = r_x[31:0];
        SUB_Y    = r_y[31:0];
        SUB_C_IN = r_bin;
        w_next   = r_wide ? S_HI : S_RESP;
      end
      S_HI: begin
        SUB_X    = r_x[63:32];
        SUB_Y    = r_y[63:32];
        SUB_C_IN = r_borrow;
        w_next   = S_RESP;
      end
      S_RESP: begin
        RSP_VALID = 1'b1;
        RSP_ID    = r_id;
        RSP_Z     = r_z;
        RSP_B_OUT = r_borrow;
        if (RSP_READY) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch on grant, then one capture per subtractor pass. r_z is
  // cleared on grant so a narrow result carries zeros in [63:32].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last   <= 1'b1;
      r_x      <= 64'd0;
      r_y      <= 64'd0;
      r_z      <= 64'd0;
      r_wide   <= 1'b0;
      r_bin    <= 1'b0;
      r_id     <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_x      <= w_gnt1 ? REQ1_X    : REQ0_X;
            r_y      <= w_gnt1 ? REQ1_Y    : REQ0_Y;
            r_wide   <= w_gnt1 ? REQ1_WIDE : REQ0_WIDE;
            r_bin    <= w_gnt1 ? REQ1_B_IN : REQ0_B_IN;
            r_id     <= w_gnt1;
            r_last   <= w_gnt1;
            r_z      <= 64'd0;
            r_borrow <= 1'b0;
          end
        end
        S_LO: begin
          r_z[31:0] <= SUB_Z;
          r_borrow  <= SUB_C_OUT;
        end
        S_HI: begin
          r_z[63:32] <= SUB_Z;
          r_borrow   <= SUB_C_OUT;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [STAT_W-1:0] r_cnt0, r_cnt1;
  logic              w_done;

  assign w_done = RSP_VALID && RSP_READY;

  // Counts hold at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_done) begin
      if (!r_id && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if ( r_id && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign STAT_CNT0 = r_cnt0;
  assign STAT_CNT1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_sub_seq_ctrl.sv
// Bench for alu_sub_seq_ctrl: directed vectors pushed to a scoreboard at
// grant time, a monitor pops and compares on each response handshake.
module tb_alu_sub_seq_ctrl;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        v[2];
  logic [63:0] x[2], y[2];
  logic        wd[2], bi[2];
  logic        rsp_rdy;

  logic        REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID, RSP_B_OUT;
  logic [63:0] RSP_Z;
  logic [31:0] SUB_X, SUB_Y, SUB_Z;
  logic        SUB_C_IN, SUB_C_OUT;

  // Model of the external subtractor: bit 32 of the 33-bit result is the borrow.
  assign {SUB_C_OUT, SUB_Z} = {1'b0, SUB_X} - {1'b0, SUB_Y} - {32'd0, SUB_C_IN};

`ifdef ALU_SEQ_STATS_EN
  logic [1:0] STAT_CNT0, STAT_CNT1;
  alu_sub_seq_ctrl #(.STAT_W(2)) dut (
`else
  alu_sub_seq_ctrl dut (
`endif
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(v[0]), .REQ0_READY(REQ0_READY), .REQ0_X(x[0]), .REQ0_Y(y[0]),
    .REQ0_WIDE(wd[0]), .REQ0_B_IN(bi[0]),
    .REQ1_VALID(v[1]), .REQ1_READY(REQ1_READY), .REQ1_X(x[1]), .REQ1_Y(y[1]),
    .REQ1_WIDE(wd[1]), .REQ1_B_IN(bi[1]),
    .RSP_VALID(RSP_VALID), .RSP_READY(rsp_rdy), .RSP_ID(RSP_ID), .RSP_Z(RSP_Z),
    .RSP_B_OUT(RSP_B_OUT),
    .SUB_X(SUB_X), .SUB_Y(SUB_Y), .SUB_C_IN(SUB_C_IN), .SUB_Z(SUB_Z),
    .SUB_C_OUT(SUB_C_OUT)
`ifdef ALU_SEQ_STATS_EN
    , .STAT_CNT0(STAT_CNT0), .STAT_CNT1(STAT_CNT1)
`endif
  );

  typedef struct {
    logic        id;
    logic [63:0] x, y;
    logic        wd, bi;
    logic [63:0] z;
    logic        b;
  } vec_t;

  typedef struct {
    logic        id;
    logic [63:0] z;
    logic        b;
    logic        wd;
    int          acc;
  } exp_t;

  vec_t V[7];
  exp_t sbq[$];
  bit   gq[$];           // expected grant order, when a test cares
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   gnt_cyc[2];
  int   n_done[2];
  bit   busy = 0, pv = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a request and hold it until granted; push the expected result.
  task automatic drive(input vec_t t, input bit push);
    int  n = 0;
    int  i = t.id ? 1 : 0;
    bit  got = 0;
    exp_t e;
    v[i] = 1'b1; x[i] = t.x; y[i] = t.y; wd[i] = t.wd; bi[i] = t.bi;
    while (!got && n < 200) begin
      @(negedge CLK);
      got = (i == 0) ? REQ0_READY : REQ1_READY;
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout: requester %0d got no READY within %0d cycles", i, n);
    end else begin
      gnt_cyc[i] = cyc;
      if (push) begin
        e.id = t.id; e.z = t.z; e.b = t.b; e.wd = t.wd; e.acc = cyc;
        sbq.push_back(e);
      end
    end
    @(posedge CLK); #1;
    v[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge CLK); #1;
  endtask

  // Monitor: grant legality and response scoreboard.
  initial begin
    exp_t e;
    bit   g;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        busy = 0; pv = 0; n_done[0] = 0; n_done[1] = 0;
        continue;
      end
      if (REQ0_READY || REQ1_READY) begin
        checks++;
        if (REQ0_READY && REQ1_READY) begin
          errors++; $display("FAIL ready_excl: both READY high at cycle %0d", cyc);
        end
        checks++;
        if (busy) begin
          errors++; $display("FAIL ready_busy: READY while op in flight at cycle %0d", cyc);
        end
        busy = 1;
        if (gq.size() > 0) begin
          g = gq.pop_front();
          chk("grant_order", {63'd0, REQ1_READY}, {63'd0, g});
        end
      end
      if (RSP_VALID) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_rsp: RSP_VALID with nothing expected at cycle %0d", cyc);
        end else begin
          e = sbq[0];
          if (!pv) chk("latency", cyc - e.acc, e.wd ? 3 : 2);
          chk("rsp_id", {63'd0, RSP_ID}, {63'd0, e.id});
          chk("rsp_z", RSP_Z, e.z);
          chk("rsp_b", {63'd0, RSP_B_OUT}, {63'd0, e.b});
          if (rsp_rdy) begin
            void'(sbq.pop_front());
            busy = 0;
            hs_cyc = cyc;
            n_done[e.id ? 1 : 0]++;
          end
        end
      end
      pv = RSP_VALID && !rsp_rdy;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    V[0] = '{1'b0, 64'h0, 64'h1, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1};
    V[1] = '{1'b1, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0};
    V[2] = '{1'b0, 64'hDEAD_BEEF_0000_0010, 64'h5, 1'b0, 1'b1, 64'h0000_0000_0000_000A, 1'b0};
    V[3] = '{1'b1, 64'h0, 64'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    V[4] = '{1'b0, 64'h8000_0000_0000_0005, 64'h0000_0001_0000_0003, 1'b1, 1'b0,
             64'h7FFF_FFFF_0000_0002, 1'b0};
    V[5] = '{1'b1, 64'h5, 64'h5, 1'b0, 1'b0, 64'h0, 1'b0};
    V[6] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0,
             64'h0123_4567_89AB_CDDF, 1'b0};
    for (int i = 0; i < 2; i++) begin
      x[i] = 64'd0; y[i] = 64'd0; wd[i] = 1'b0; bi[i] = 1'b0; n_done[i] = 0; gnt_cyc[i] = 0;
    end
    rsp_rdy = 1'b1;
    // Requests are valid during reset; READY must still read 0.
    v[0] = 1'b1; v[1] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready0", {63'd0, REQ0_READY}, 0);
    chk("rst_ready1", {63'd0, REQ1_READY}, 0);
    chk("rst_rsp_valid", {63'd0, RSP_VALID}, 0);
    chk("rst_rsp_z", RSP_Z, 0);
    chk("rst_sub_x", {32'd0, SUB_X}, 0);
    chk("rst_sub_cin", {63'd0, SUB_C_IN}, 0);
    v[0] = 1'b0; v[1] = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Contention straight out of reset: grants must go 0,1,0,1.
    gq = '{1'b0, 1'b1, 1'b0, 1'b1};
    fork
      begin drive(V[0], 1); drive(V[2], 1); end
      begin drive(V[1], 1); drive(V[3], 1); end
    join
    wait_idle();
    chk("grant_order_done", gq.size(), 0);

    // Wide borrow chain: look at the subtractor drive on each pass.
    drive(V[1], 1);
    chk("lo_sub_x", {32'd0, SUB_X}, 64'h0);
    chk("lo_sub_y", {32'd0, SUB_Y}, 64'h1);
    chk("lo_sub_cin", {63'd0, SUB_C_IN}, 0);
    @(posedge CLK); #1;
    chk("hi_sub_x", {32'd0, SUB_X}, 64'h1);
    chk("hi_sub_y", {32'd0, SUB_Y}, 64'h0);
    chk("hi_sub_cin", {63'd0, SUB_C_IN}, 1);
    @(posedge CLK); #1;
    chk("resp_sub_x", {32'd0, SUB_X}, 0);
    chk("resp_sub_cin", {63'd0, SUB_C_IN}, 0);
    wait_idle();

    // Assorted single ops.
    for (int k = 2; k < 7; k++) drive(V[k], 1);
    wait_idle();

    // Backpressure: response held 5 cycles, requester 1 waits meanwhile.
    rsp_rdy = 1'b0;
    drive(V[6], 1);
    begin
      int n = 0;
      while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
      chk("bp_rsp_seen", {63'd0, RSP_VALID}, 1);
    end
    fork
      drive(V[3], 1);
      begin repeat (5) @(posedge CLK); #1; rsp_rdy = 1'b1; end
    join
    chk("bp_next_grant", gnt_cyc[1], hs_cyc + 1);
    wait_idle();

    // Reset during the high pass of a wide op: nothing may come out.
    drive(V[6], 0);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, RSP_VALID}, 0);
    chk("mid_rst_sub_x", {32'd0, SUB_X}, 0);
    chk("mid_rst_sub_y", {32'd0, SUB_Y}, 0);
    chk("mid_rst_sub_cin", {63'd0, SUB_C_IN}, 0);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    gq = '{1'b0, 1'b1};
    fork
      drive(V[0], 1);
      drive(V[5], 1);
    join
    wait_idle();
    chk("post_rst_grants", gq.size(), 0);

`ifdef ALU_SEQ_STATS_EN
    for (int k = 0; k < 5; k++) drive(V[0], 1);
    wait_idle();
    chk("stat_cnt0", {62'd0, STAT_CNT0}, (n_done[0] > 3) ? 3 : n_done[0]);
    chk("stat_cnt1", {62'd0, STAT_CNT1}, (n_done[1] > 3) ? 3 : n_done[1]);
`endif

    repeat (4) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sub_seq_ctrl.md
Name: alu_sub_seq_ctrl

Overview:
Sequencer and arbiter that shares one combinational subtract_32bit unit between two requesters. Each request is either a 32-bit subtract or a 64-bit subtract; a 64-bit subtract runs as two passes through the unit, low word first, with the borrow chained into the high word. Results are returned over a single response channel tagged with the requester ID. The block sits between the requesters and the subtractor, and owns the subtractor's X/Y/C_IN inputs exclusively.

Parameters:
STAT_W, 16, width of the per-requester operation counters (only used with ALU_SEQ_STATS_EN)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ0_VALID  in  1  requester 0 has a request
REQ0_READY  out  1  request 0 accepted this cycle
REQ0_X  in  64  minuend; bits [63:32] ignored if narrow
REQ0_Y  in  64  subtrahend
REQ0_WIDE  in  1  1 = 64-bit op, 0 = 32-bit op
REQ0_B_IN  in  1  borrow-in
REQ1_VALID / REQ1_READY / REQ1_X / REQ1_Y / REQ1_WIDE / REQ1_B_IN  same as requester 0
RSP_VALID  out  1  result valid
RSP_READY  in  1  consumer accepts result
RSP_ID  out  1  requester that owns the result
RSP_Z  out  64  difference; [63:32]=0 for narrow ops
RSP_B_OUT  out  1  final borrow-out
SUB_X  out  32  to subtractor X
SUB_Y  out  32  to subtractor Y
SUB_C_IN  out  1  to subtractor C_IN (borrow-in)
SUB_Z  in  32  from subtractor Z
SUB_C_OUT  in  1  from subtractor C_OUT (borrow-out)

Behaviour:
- Subtractor contract: combinational, Z = X - Y - C_IN mod 2^32, C_OUT = borrow. Outputs are sampled in the same cycle the inputs are driven.
- FSM states: IDLE, LO, HI, RESP. Reset: state=IDLE, last_grant=1, all outputs and registers 0.
- IDLE: if any REQn_VALID, grant one, assert its REQn_READY for exactly that cycle, latch X/Y/WIDE/B_IN/ID, then go to LO. READY is never asserted outside IDLE, and never to both requesters.
- Arbitration: if only one is valid, grant it. If both are valid, grant the one != last_grant. last_grant updates on every grant, so requester 0 wins the first contention after reset.
- LO: drive SUB_X/SUB_Y with the latched low words and SUB_C_IN=B_IN. Capture SUB_Z into Z[31:0] and SUB_C_OUT into the borrow register. Go to HI if WIDE, otherwise RESP.
- HI: drive the high words with SUB_C_IN = captured borrow. Capture Z[63:32] and the borrow. Go to RESP.
- RESP: RSP_VALID=1, with RSP_ID/RSP_Z/RSP_B_OUT held stable until RSP_READY. On RSP_READY, go to IDLE. The next grant is earliest the cycle after.
- Latency, with accept at cycle N: narrow gives RSP_VALID from cycle N+2; wide gives it from N+3. Throughput is one op per 3 (narrow) or 4 (wide) cycles with RSP_READY=1.
- SUB_* outputs are 0 in IDLE and RESP.
- Narrow op: RSP_Z[63:32]=0, and RSP_B_OUT = borrow from the low pass.
- Reset mid-operation: state returns to IDLE immediately. The in-flight result is discarded with no RSP_VALID, and last_grant=1.
- Requests held VALID while not granted must stay stable. No starvation: under continuous contention, grants alternate 0,1,0,1.

Optional Feature:
ALU_SEQ_STATS_EN: when defined, adds outputs STAT_CNT0 and STAT_CNT1 (STAT_W bits each). Each counts completed responses (RSP_VALID & RSP_READY) per RSP_ID and saturates at all-ones. Both reset to 0 on RST_N. When undefined, the ports and counters are absent and the rest of the behaviour is unchanged.

Test Plan:
- Narrow: REQ0 X=0x0, Y=0x1, B_IN=0 -> RSP_Z=0x0000_0000_FFFF_FFFF, RSP_B_OUT=1, RSP_ID=0, RSP_VALID 2 cycles after READY.
- Wide borrow chain: REQ1 X=0x0000_0001_0000_0000, Y=0x1, WIDE=1 -> low pass SUB_C_OUT=1, high pass SUB_C_IN=1; RSP_Z=0x0000_0000_FFFF_FFFF, RSP_B_OUT=0, latency 3.
- Contention: after reset, both valid continuously -> grant order 0,1,0,1. READY is never high in both requesters or outside IDLE.
- Backpressure: RSP_READY=0 for 5 cycles -> RSP_* held stable, no new READY; RSP_READY=1 -> IDLE next cycle.
- Reset mid-op: assert RST_N=0 during HI of a wide op -> all outputs 0 asynchronously, no response emitted; the next contended grant goes to requester 0.
- Stats (ALU_SEQ_STATS_EN, STAT_W=2): 5 requester-0 ops -> STAT_CNT0 saturates at 3, STAT_CNT1=0.
